cpu_phase_sequencer: RTL and testbench
======================================

// Module: cpu_phase_sequencer
// PURPOSE
//  Multicycle controller that sequences the LEGv8 datapath (fetch, decode/regfile, ALU, data memory, writeback)
//  one instruction at a time. It turns the decode-stage control flags into per-phase enable strobes, including
//  the regfile read/write strobes and the PC update. It handshakes with data memory and stops on a HALT opcode,
//  on an external halt request, or on a memory timeout.
// PARAMETERS
//  HALT_OPCODE  11'h7FF  Instruction[31:21] value treated as HALT
//  MEM_TIMEOUT  16       max cycles in MEM waiting for mem_ack before error (>=1)
//  COUNT_W      32       width of retired-instruction counter
// PORTS
//  clk            in   1        single clock, rising edge
//  reset          in   1        synchronous, active-high
//  start          in   1        begin/resume execution (honoured in IDLE and HALT only)
//  halt_req       in   1        stop at next instruction boundary
//  opcode         in   11       Instruction[31:21] from decode
//  mem_read       in   1        decode flag: load
//  mem_write      in   1        decode flag: store
//  branch         in   1        decode flag: conditional branch
//  uncond_branch  in   1        decode flag: unconditional branch
//  mem_ack        in   1        data memory completes access this cycle
//  fetch_en       out  1        instruction register load strobe
//  decode_en      out  1        regfile read strobe
//  exec_en        out  1        ALU/flag register strobe
//  mem_req        out  1        data memory request, held until ack
//  wb_en          out  1        regfile write strobe
//  pc_en          out  1        PC update strobe (last cycle of instruction)
//  busy           out  1        1 in any state except IDLE/HALT/ERR
//  halted         out  1        1 in HALT
//  err            out  1        1 in ERR (memory timeout)
//  state          out  3        current state encoding
//  retired_count  out  COUNT_W  instructions retired (see CONFIGURATION)
// BEHAVIOUR
//  - States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6 ERR=7. State is registered.
//    All strobes are Moore outputs decoded from state, active in the same cycle the state is entered.
//  - Reset: state=IDLE; all outputs 0; timeout counter 0; latched halt request cleared; retired_count=0.
//    Reset asserted mid-instruction aborts it; nothing commits (no pc_en/wb_en).
//  - IDLE: start -> FETCH. halt_req ignored.
//  - FETCH: fetch_en=1; -> DECODE.
//  - DECODE: decode_en=1; opcode==HALT_OPCODE -> HALT (no pc_en); else -> EXEC.
//  - EXEC: exec_en=1; priority: (mem_read|mem_write) -> MEM; (branch|uncond_branch) -> boundary with pc_en=1;
//    else -> WB.
//  - MEM: mem_req=1 every cycle. Timeout counter increments each MEM cycle.
//    mem_ack in a MEM cycle: mem_read -> WB; else (store) pc_en=1 and go to boundary.
//    Counter reaching MEM_TIMEOUT with no ack -> ERR. Ack on the final permitted cycle wins over timeout.
//    Counter clears on MEM exit.
//  - WB: wb_en=1, pc_en=1; -> boundary.
//  - pc_en is a Mealy output on the instruction's final cycle (EXEC branch, MEM store-ack, WB).
//  - Boundary: halt_req seen any cycle since the instruction's FETCH (latched) -> IDLE; else -> FETCH.
//    The latch clears on entering IDLE.
//  - HALT: halted=1; start -> FETCH (opcode re-fetched from the next PC is the caller's concern).
//  - ERR: err=1; exited only by reset. start is ignored.
//  - mem_ack outside MEM is ignored. Decode flags are sampled only in EXEC/MEM. Mutually-exclusive flags are not checked.
//  - Cycle counts (ack on first MEM cycle): R-type 4, LDUR 5, STUR 4, CBZ/B 3.
// CONFIGURATION
//  PERF_COUNT_EN defined: retired_count increments by 1 on every cycle with pc_en=1, saturating at all-ones.
//  PERF_COUNT_EN undefined: retired_count port present, tied to 0; no counter logic.
// TESTING
//  1. reset, start, opcode=11'h458 (ADD), no flags -> states 1,2,3,5; wb_en and pc_en high in cycle 4; back to FETCH.
//  2. LDUR 11'h7C2, mem_read=1, mem_ack after 3 MEM cycles -> mem_req high 3 cycles; then WB with wb_en; 7 cycles total.
//  3. STUR 11'h7C0, mem_write=1, ack immediate -> pc_en in MEM cycle; wb_en never asserted; 4 cycles.
//  4. CBZ 11'h5A0, branch=1 -> pc_en in EXEC; 3 cycles. halt_req pulsed in DECODE -> IDLE after EXEC; busy=0.
//  5. mem_read=1, mem_ack never, MEM_TIMEOUT=16 -> 16 MEM cycles, then ERR with err=1; start ignored; reset -> IDLE.
//  6. opcode=11'h7FF -> HALT after DECODE, pc_en never; with PERF_COUNT_EN, retired_count unchanged; start -> FETCH.

Source files
------------

// File: rtl/cpu_phase_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_phase_sequencer_if
// Brief    : Handshake/strobe bundle between the phase sequencer and datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_phase_sequencer_if #(
    parameter int COUNT_W = 32
);
    logic               start;
    logic               halt_req;
    logic [10:0]        opcode;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic               uncond_branch;
    logic               mem_ack;
    logic               fetch_en;
    logic               decode_en;
    logic               exec_en;
    logic               mem_req;
    logic               wb_en;
    logic               pc_en;
    logic               busy;
    logic               halted;
    logic               err;
    logic [2:0]         state;
    logic [COUNT_W-1:0] retired_count;

    modport master (
        output start, halt_req, opcode, mem_read, mem_write, branch, uncond_branch, mem_ack,
        input  fetch_en, decode_en, exec_en, mem_req, wb_en, pc_en, busy, halted, err,
               state, retired_count
    );

    modport slave (
        input  start, halt_req, opcode, mem_read, mem_write, branch, uncond_branch, mem_ack,
        output fetch_en, decode_en, exec_en, mem_req, wb_en, pc_en, busy, halted, err,
               state, retired_count
    );
endinterface
`default_nettype wire

// File: rtl/cpu_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_phase_sequencer
// Brief    : Multicycle LEGv8 phase controller; optional PERF_COUNT_EN macro
//            enables the saturating retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_phase_sequencer #(
    parameter logic [10:0] HALT_OPCODE = 11'h7FF,
    parameter int          MEM_TIMEOUT = 16,
    parameter int          COUNT_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_phase_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    localparam int               TMO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d, boundary;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             halt_lat_q, halt_lat_d;
    logic             pc_en_raw;
    logic             busy_w;

    assign busy_w = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                    (state_q == ST_MEM)   || (state_q == ST_WB);

    always_comb begin
        state_d    = state_q;
        tmo_d      = '0;
        pc_en_raw  = 1'b0;
        // halt_req in the instruction's final cycle still counts toward the boundary decision
        boundary   = (halt_lat_q || bus.halt_req) ? ST_IDLE : ST_FETCH;
        case (state_q)
            ST_IDLE:   if (bus.start) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = (bus.opcode == HALT_OPCODE) ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                if (bus.mem_read || bus.mem_write) begin
                    state_d = ST_MEM;
                end else if (bus.branch || bus.uncond_branch) begin
                    pc_en_raw = 1'b1;
                    state_d   = boundary;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (bus.mem_ack) begin
                    if (bus.mem_read) begin
                        state_d = ST_WB;
                    end else begin
                        pc_en_raw = 1'b1;
                        state_d   = boundary;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_WB: begin
                pc_en_raw = 1'b1;
                state_d   = boundary;
            end
            ST_HALT:   if (bus.start) state_d = ST_FETCH;
            ST_ERR:    state_d = ST_ERR;
            default:   state_d = ST_IDLE;
        endcase

        // The latch only tracks the instruction in flight, so it restarts at each FETCH.
        halt_lat_d = halt_lat_q || (busy_w && bus.halt_req);
        if ((state_d == ST_IDLE) || (state_d == ST_FETCH)) begin
            halt_lat_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tmo_q      <= '0;
            halt_lat_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            halt_lat_q <= halt_lat_d;
        end
    end

    // Strobes are masked during reset so an aborted instruction never commits.
    assign bus.fetch_en  = !reset && (state_q == ST_FETCH);
    assign bus.decode_en = !reset && (state_q == ST_DECODE);
    assign bus.exec_en   = !reset && (state_q == ST_EXEC);
    assign bus.mem_req   = !reset && (state_q == ST_MEM);
    assign bus.wb_en     = !reset && (state_q == ST_WB);
    assign bus.pc_en     = !reset && pc_en_raw;
    assign bus.busy      = busy_w;
    assign bus.halted    = (state_q == ST_HALT);
    assign bus.err       = (state_q == ST_ERR);
    assign bus.state     = state_q;

`ifdef PERF_COUNT_EN
    logic [COUNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (pc_en_raw && (count_q != {COUNT_W{1'b1}})) begin
            count_q <= count_q + COUNT_W'(1);
        end
    end

    assign bus.retired_count = count_q;
`else
    assign bus.retired_count = {COUNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_phase_sequencer
// Brief    : Randomized scoreboard bench for cpu_phase_sequencer (PERF_COUNT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_phase_sequencer;

    localparam int COUNT_W = 4;
    localparam int MEM_TO  = 16;

    localparam logic [2:0] P_IDLE = 3'd0, P_FETCH = 3'd1, P_DECODE = 3'd2, P_EXEC = 3'd3,
                           P_MEM  = 3'd4, P_WB    = 3'd5, P_HALT   = 3'd6, P_ERR  = 3'd7;
    localparam int K_R = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_HLT = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_ERR = 3;

    typedef struct {
        bit                 rst;
        logic [2:0]         st;
        logic               pc;
        logic [COUNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_phase_sequencer_if #(.COUNT_W(COUNT_W)) bus ();

    cpu_phase_sequencer #(
        .HALT_OPCODE (11'h7FF),
        .MEM_TIMEOUT (MEM_TO),
        .COUNT_W     (COUNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t               sb[$];
    int                 n_vec = 0;
    int                 n_bad = 0;
    int                 mode  = M_IDLE;
    logic [COUNT_W-1:0] ret_m = '0;

    function automatic logic [COUNT_W-1:0] retire(input logic [COUNT_W-1:0] c);
`ifdef PERF_COUNT_EN
        return (c == {COUNT_W{1'b1}}) ? c : c + COUNT_W'(1);
`else
        return c;
`endif
    endfunction

    // {fetch, decode, exec, mem_req, wb, pc, busy, halted, err}
    function automatic logic [8:0] exp_vec(input logic [2:0] st, input logic pc);
        return {st == P_FETCH, st == P_DECODE, st == P_EXEC, st == P_MEM, st == P_WB, pc,
                (st >= P_FETCH) && (st <= P_WB), st == P_HALT, st == P_ERR};
    endfunction

    function automatic logic [10:0] rnd_op();
        logic [10:0] op;
        do op = 11'($urandom); while (op == 11'h7FF);
        return op;
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show during that cycle.
    task automatic cyc(input logic [2:0] st, input bit pc, input bit go, input bit hr,
                       input logic [10:0] op, input logic [3:0] fl, input bit ack, input bit rs);
        exp_t e;
        reset             = rs;
        bus.start         = go;
        bus.halt_req      = hr;
        bus.opcode        = op;
        {bus.mem_read, bus.mem_write, bus.branch, bus.uncond_branch} = fl;
        bus.mem_ack       = ack;
        e.rst = rs; e.st = st; e.pc = pc; e.cnt = ret_m;
        sb.push_back(e);
        if (pc && !rs) ret_m = retire(ret_m);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        repeat (n) cyc(P_IDLE, 0, 1'($urandom), 1'($urandom), 11'($urandom), 4'($urandom),
                       1'($urandom), 1'b1);
        ret_m = '0;
        mode  = M_IDLE;
    endtask

    // Wait n cycles in IDLE or HALT with start low, then one cycle with start high.
    task automatic park(input logic [2:0] st, input int n);
        repeat (n) cyc(st, 0, 1'b0, 1'($urandom), 11'($urandom), 4'($urandom), 1'($urandom), 1'b0);
        cyc(st, 0, 1'b1, 1'($urandom), 11'($urandom), 4'($urandom), 1'($urandom), 1'b0);
        mode = M_RUN;
    endtask

    task automatic sit_err(input int n);
        repeat (n) cyc(P_ERR, 0, 1'($urandom), 1'($urandom), 11'($urandom), 4'($urandom),
                       1'($urandom), 1'b0);
        do_reset(2);
    endtask

    // halt_at: -1 never, -2 random, >=0 that phase index; abort_at: phase index reset fires on.
    task automatic do_instr(input int kind, input int delay, input int halt_at, input int abort_at,
                            input logic [10:0] opc);
        logic [2:0] ph[$];
        logic [3:0] fl;
        logic [1:0] r;
        bit timeout, seen, hr, pc, ack;
        timeout = ((kind == K_LD) || (kind == K_ST)) && (delay + 1 > MEM_TO);
        seen    = 1'b0;
        ph = '{P_FETCH, P_DECODE};
        if (kind != K_HLT) ph.push_back(P_EXEC);
        if ((kind == K_LD) || (kind == K_ST))
            repeat (timeout ? MEM_TO : delay + 1) ph.push_back(P_MEM);
        if ((kind == K_R) || ((kind == K_LD) && !timeout)) ph.push_back(P_WB);
        r = 2'($urandom_range(1, 3));
        case (kind)
            K_LD:    fl = {1'b1, 1'($urandom), 1'($urandom), 1'($urandom)};
            K_ST:    fl = {1'b0, 1'b1, 1'($urandom), 1'($urandom)};
            K_BR:    fl = {2'b00, r};
            default: fl = 4'b0000;
        endcase
        for (int i = 0; i < ph.size(); i++) begin
            if (i == abort_at) begin
                do_reset(2);
                return;
            end
            hr   = (halt_at == i) || ((halt_at == -2) && ($urandom_range(0, 14) == 0));
            seen = seen || hr;
            pc   = (i == ph.size() - 1) && (kind != K_HLT) && !timeout;
            ack  = (ph[i] == P_MEM) ? (!timeout && (i == 3 + delay)) : 1'($urandom);
            cyc(ph[i], pc, 1'($urandom), hr,
                (ph[i] == P_DECODE) ? opc : 11'($urandom),
                ((ph[i] == P_EXEC) || (ph[i] == P_MEM)) ? fl : 4'($urandom), ack, 1'b0);
        end
        if (timeout)            mode = M_ERR;
        else if (kind == K_HLT) mode = M_HALT;
        else if (seen)          mode = M_IDLE;
        else                    mode = M_RUN;
    endtask

    // Monitor: every queued cycle is compared against the live outputs mid-cycle.
    initial begin
        exp_t       e;
        logic [8:0] got;
        logic [8:0] want;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                got = {bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_req, bus.wb_en, bus.pc_en,
                       bus.busy, bus.halted, bus.err};
                n_vec++;
                if (e.rst) begin
                    if (bus.pc_en !== 1'b0 || bus.wb_en !== 1'b0) begin
                        n_bad++;
                        $display("FAIL reset_commit t=%0t: pc_en=%b wb_en=%b, required 0 0",
                                 $time, bus.pc_en, bus.wb_en);
                    end
                end else begin
                    want = exp_vec(e.st, e.pc);
                    if (bus.state !== e.st || got !== want || bus.retired_count !== e.cnt) begin
                        n_bad++;
                        $display("FAIL phase t=%0t: got state=%0d strobes=%b count=%0d, required state=%0d strobes=%b count=%0d",
                                 $time, bus.state, got, bus.retired_count, e.st, want, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        int kind, d, ab;
        reset = 1'b1;
        bus.start = 1'b0; bus.halt_req = 1'b0; bus.opcode = '0; bus.mem_ack = 1'b0;
        {bus.mem_read, bus.mem_write, bus.branch, bus.uncond_branch} = 4'b0;
        @(posedge clk); #1;
        do_reset(2);

        park(P_IDLE, 2);
        do_instr(K_R,  0, -1, -1, 11'h458);
        do_instr(K_LD, 2, -1, -1, 11'h7C2);
        do_instr(K_ST, 0, -1, -1, 11'h7C0);
        do_instr(K_BR, 0,  1, -1, 11'h5A0);
        park(P_IDLE, 3);
        do_instr(K_LD, MEM_TO - 1, -1, -1, 11'h7C2);
        do_instr(K_HLT, 0, -1, -1, 11'h7FF);
        park(P_HALT, 3);
        do_instr(K_R, 0, -1, 3, 11'h458);
        park(P_IDLE, 1);
        do_instr(K_LD, 99, -1, -1, 11'h7C2);
        sit_err(4);

        for (int n = 0; n < 300; n++) begin
            case (mode)
                M_IDLE:  park(P_IDLE, $urandom_range(0, 2));
                M_HALT:  park(P_HALT, $urandom_range(0, 2));
                M_ERR:   begin sit_err($urandom_range(1, 3)); park(P_IDLE, 0); end
                default: ;
            endcase
            kind = ($urandom_range(0, 19) == 0) ? K_HLT : $urandom_range(0, 3);
            d    = $urandom_range(0, 3);
            if ($urandom_range(0, 24) == 0) d = MEM_TO - 1 + $urandom_range(0, 1);
            ab   = ($urandom_range(0, 29) == 0) ? $urandom_range(0, 2) : -1;
            do_instr(kind, d, -2, ab, (kind == K_HLT) ? 11'h7FF : rnd_op());
        end

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected cycles left unchecked, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
